// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI mode-0 slave transmitter (MISO side), MSB first.
// Bytes from the fabric are queued in a small FIFO and shifted out on
// master sclk falling edges. sclk/cs_n are synchronised into the clk domain.
// When the FIFO is empty at a word boundary, FILL_BYTE is sent and underrun pulses.
// Optional feature macro: SPI_TX_MISO_OE_EN adds a miso_oe output for pad tristating.
//
// Handshake (tx side): a byte is accepted on any clk where tx_valid && tx_ready;
// tx_ready depends only on the registered FIFO level, never on tx_valid.
module spi_slave_tx #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          cs_n,
`ifdef SPI_TX_MISO_OE_EN
  output logic                          miso_oe,
`endif
  output logic                          miso,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          byte_sent,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_CS_HIGH, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sclk_sync;
  logic [1:0]              cs_n_sync;
  logic                    cs_act, cs_act_q, cs_rise, sclk_fall;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level;
  logic                    push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [CW-1:0]           bit_cnt;
  logic                    from_fifo;
  logic                    load, shift_en, abort;

  assign cs_act     = ~cs_n_sync[1];
  assign cs_rise    = cs_act & ~cs_act_q;
  assign sclk_fall  = sclk_sync[2] & ~sclk_sync[1];
  assign fifo_empty = (level == '0);
  assign tx_ready   = (level != LW'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  // A load on an empty FIFO sends FILL_BYTE; a same-clk push is simply stored.
  assign pop        = load & ~fifo_empty;
  assign fifo_level = level;

  // Synchronisers run through reset so the reset branch can see the real CS level.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[1:0], sclk};
    cs_n_sync <= {cs_n_sync[0], cs_n};
    cs_act_q  <= cs_act;
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // State register; reset during an active frame parks in WAIT_CS_HIGH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= cs_act ? WAIT_CS_HIGH : IDLE;
    else     state_q <= state_d;
  end

  // Next-state and shift-control decode.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      WAIT_CS_HIGH: begin
        if (!cs_act) state_d = IDLE;
      end
      SHIFT: begin
        if (!cs_act) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt == CW'(DATA_WIDTH - 1)) load     = 1'b1;
          else                                shift_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next shift register contents: fresh word on load, else shift left.
  always_comb begin
    shift_next = shift_reg;
    if (load)          shift_next = fifo_empty ? FILL_BYTE : mem[rd_ptr];
    else if (shift_en) shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
  end

  // Shift datapath, MISO register and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      from_fifo <= 1'b0;
      miso      <= 1'b0;
      byte_sent <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      byte_sent <= load && (state_q == SHIFT) && from_fifo;
      underrun  <= load && fifo_empty;
      miso      <= (state_d == SHIFT) ? shift_next[DATA_WIDTH-1] : 1'b0;
      if (load) begin
        bit_cnt   <= '0;
        from_fifo <= ~fifo_empty;
      end else if (shift_en) begin
        bit_cnt   <= bit_cnt + CW'(1);
      end else if (abort) begin
        bit_cnt   <= '0;
      end
    end
  end

`ifdef SPI_TX_MISO_OE_EN
  // Output enable follows the shifting state (CS active and a frame in progress).
  always_ff @(posedge clk) begin
    if (rst) miso_oe <= 1'b0;
    else     miso_oe <= (state_d == SHIFT);
  end
`endif

endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: self-checking bench for spi_slave_tx.
// Acts as a mode-0 SPI master and compares every sampled MISO bit, pulse count
// and FIFO level against a queue-based model of the byte stream.
module tb_spi_slave_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = 8;

  logic        clk, rst, sclk, cs_n, miso, tx_valid, tx_ready, byte_sent, underrun;
  logic [7:0]  tx_data;
  logic [2:0]  fifo_level;
`ifdef SPI_TX_MISO_OE_EN
  logic        miso_oe;
`endif

  int          checks;
  int          failures;
  int          bs_cnt;
  int          ur_cnt;
  logic [7:0]  model_q[$];
  logic [7:0]  cur_word;
  bit          cur_from_fifo;
  int          exp_bs;
  int          exp_ur;
  logic [7:0]  fill_byte;

  spi_slave_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FILL_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
`ifdef SPI_TX_MISO_OE_EN
    .miso_oe    (miso_oe),
`endif
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .byte_sent  (byte_sent),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (byte_sent === 1'b1) bs_cnt <= bs_cnt + 1;
    if (underrun === 1'b1)  ur_cnt <= ur_cnt + 1;
  end

  // Model: next word the slave should present (head of queue, or fill on underrun)
  task automatic model_load();
    if (model_q.size() > 0) begin
      cur_word      = model_q.pop_front();
      cur_from_fifo = 1'b1;
    end else begin
      cur_word      = fill_byte;
      cur_from_fifo = 1'b0;
      exp_ur        = exp_ur + 1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit exp_rdy;
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    exp_rdy  = (model_q.size() < DEPTH);
    @(negedge clk);
    checks++;
    if (tx_ready !== exp_rdy) begin
      failures++;
      $display("FAIL tx_ready: got %0b expected %0b", tx_ready, exp_rdy);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (exp_rdy) model_q.push_back(b);
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'(model_q.size())) begin
      failures++;
      $display("FAIL push_level: got %0d expected %0d", fifo_level, model_q.size());
    end
  endtask

  // Master frame: n_bits rising edges; end_fall adds the final falling edge inside CS.
  task automatic run_frame(input int n_bits, input bit end_fall);
    int bs0;
    int ur0;
    int bitpos;
    bs0    = bs_cnt;
    ur0    = ur_cnt;
    exp_bs = 0;
    exp_ur = 0;
    model_load();
    @(posedge clk); #1;
    cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
    for (int i = 0; i < n_bits; i++) begin
      bitpos = DW - 1 - (i % DW);
      @(negedge clk);
      checks++;
      if (miso !== cur_word[bitpos]) begin
        failures++;
        $display("FAIL miso_bit %0d: got %0b expected %0b (word %02h)", i, miso, cur_word[bitpos], cur_word);
      end
      @(posedge clk); #1;
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      if (i < n_bits - 1 || end_fall) begin
        #1 sclk = 1'b0;
        if ((i % DW) == DW - 1) begin
          if (cur_from_fifo) exp_bs = exp_bs + 1;
          model_load();
        end
        repeat (HALF) @(posedge clk);
      end
    end
    #1 cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 sclk = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bs_cnt - bs0 !== exp_bs) begin
      failures++;
      $display("FAIL byte_sent_count: got %0d expected %0d", bs_cnt - bs0, exp_bs);
    end
    checks++;
    if (ur_cnt - ur0 !== exp_ur) begin
      failures++;
      $display("FAIL underrun_count: got %0d expected %0d", ur_cnt - ur0, exp_ur);
    end
    checks++;
    if (fifo_level !== 3'(model_q.size())) begin
      failures++;
      $display("FAIL frame_level: got %0d expected %0d", fifo_level, model_q.size());
    end
    checks++;
    if (miso !== 1'b0) begin
      failures++;
      $display("FAIL miso_idle: got %0b expected 0", miso);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (miso !== 1'b0 || byte_sent !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got miso=%0b bs=%0b ur=%0b expected 0 0 0", miso, byte_sent, underrun);
    end
    checks++;
    if (fifo_level !== 3'd0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fifo: got level=%0d ready=%0b expected 0 1", fifo_level, tx_ready);
    end
`ifdef SPI_TX_MISO_OE_EN
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_oe: got %0b expected 0", miso_oe);
    end
`endif
  endtask

  task automatic test_single_byte();
    push_byte(8'hA5);
    run_frame(8, 1'b1);
  endtask

  task automatic test_back_to_back();
    push_byte(8'h3C);
    push_byte(8'hC3);
    run_frame(16, 1'b1);
  endtask

  task automatic test_underrun();
    run_frame(8, 1'b0);
  endtask

  task automatic test_fifo_full();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    checks++;
    if (tx_ready !== 1'b0 || fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL full_flags: got ready=%0b level=%0d expected 0 4", tx_ready, fifo_level);
    end
    push_byte(8'h55);
    run_frame(8, 1'b1);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_send: got %0b expected 1", tx_ready);
    end
    run_frame(16, 1'b0);
  endtask

  task automatic test_abort();
    push_byte(8'hF0);
    push_byte(8'h0F);
    run_frame(4, 1'b1);
    run_frame(8, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    push_byte(8'h96);
    push_byte(8'h69);
    @(posedge clk); #1;
    cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b0;
      repeat (HALF) @(posedge clk);
    end
    #1 rst = 1'b1;
    model_q.delete();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || miso !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: got level=%0d miso=%0b ready=%0b expected 0 0 1", fifo_level, miso, tx_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b0;
      repeat (HALF) @(posedge clk);
      @(negedge clk);
      checks++;
      if (miso !== 1'b0 || bs_cnt != 0 && byte_sent === 1'b1) begin
        failures++;
        $display("FAIL wait_cs_high_miso: got %0b expected 0", miso);
      end
    end
    #1 cs_n = 1'b1;
    repeat (6) @(posedge clk);
    push_byte(8'h5A);
    run_frame(8, 1'b1);
  endtask

  task automatic test_random();
    int k;
    int nw;
    int nb;
    bit ef;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, DEPTH - model_q.size());
      for (int j = 0; j < k; j++) push_byte(8'($urandom_range(0, 255)));
      nw = $urandom_range(1, 3);
      nb = nw * DW;
      if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, DW - 1);
      ef = 1'($urandom_range(0, 1));
      run_frame(nb, ef);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    bs_cnt    = 0;
    ur_cnt    = 0;
    fill_byte = 8'h00;
    rst       = 1'b1;
    sclk      = 1'b0;
    cs_n      = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_fifo_full();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
